// File: rtl/stream_to_3d_sub_array.sv
// Serial-to-array receiver for the sub-row flat layout (region A column-major, then region B).
// Optional framing check: define STREAM_TO_3D_SUB_LAST_CHECK_EN to add in_last / frame_err.
module stream_to_3d_sub_array #(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8,
   parameter int unsigned SUB_ROWS  = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [BIT_WIDTH-1:0]                      in_data,
   input  logic                                      in_valid,
   output logic                                      in_ready,
`ifdef STREAM_TO_3D_SUB_LAST_CHECK_EN
   input  logic                                      in_last,
   output logic                                      frame_err,
`endif
   output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]  out,
   output logic                                      out_valid,
   input  logic                                      out_ready
);

   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] LastA   = RW'(SUB_ROWS - 1);
   localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);
   localparam logic [RW-1:0] FirstB  = RW'(SUB_ROWS);
   localparam logic [CW-1:0] LastCol = CW'(COLS - 1);

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e                                   r_state;
   logic [RW-1:0]                            r_row;
   logic [CW-1:0]                            r_col;
   logic                                     r_region;
   logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] r_arr;
`ifdef STREAM_TO_3D_SUB_LAST_CHECK_EN
   logic                                     r_frame_err;
`endif

   logic w_row_end;
   logic w_last_elem;

   // Row wraps at the last row of whichever region is being filled.
   assign w_row_end   = r_region ? (r_row == LastRow) : (r_row == LastA);
   assign w_last_elem = w_row_end && (r_col == LastCol) && (r_region || (SUB_ROWS == ROWS));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StFill;
         r_row    <= '0;
         r_col    <= '0;
         r_region <= 1'b0;
         r_arr    <= '0;
`ifdef STREAM_TO_3D_SUB_LAST_CHECK_EN
         r_frame_err <= 1'b0;
`endif
      end else begin
`ifdef STREAM_TO_3D_SUB_LAST_CHECK_EN
         r_frame_err <= 1'b0;
`endif
         unique case (r_state)
            StFill: begin
               if (in_valid) begin
                  r_arr[r_row][r_col] <= in_data;
                  if (w_last_elem) begin
                     r_state  <= StHold;
                     r_row    <= '0;
                     r_col    <= '0;
                     r_region <= 1'b0;
`ifdef STREAM_TO_3D_SUB_LAST_CHECK_EN
                     r_frame_err <= !in_last;
                  end else if (in_last) begin
                     // Early end of frame: restart counting, keep already-written elements.
                     r_frame_err <= 1'b1;
                     r_row       <= '0;
                     r_col       <= '0;
                     r_region    <= 1'b0;
`endif
                  end else if (!w_row_end) begin
                     r_row <= r_row + RW'(1);
                  end else if (r_col != LastCol) begin
                     r_col <= r_col + CW'(1);
                     r_row <= r_region ? FirstB : '0;
                  end else begin
                     r_row    <= FirstB;
                     r_col    <= '0;
                     r_region <= 1'b1;
                  end
               end
            end
            StHold: begin
               if (out_ready) r_state <= StFill;
            end
            default: r_state <= StFill;
         endcase
      end
   end

   assign in_ready  = (r_state == StFill);
   assign out_valid = (r_state == StHold);
   assign out       = r_arr;
`ifdef STREAM_TO_3D_SUB_LAST_CHECK_EN
   assign frame_err = r_frame_err;
`endif

endmodule
